// File: rtl/down_counter_seq.sv
// rtl/down_counter_seq.sv - loadable down-counting index sequencer (start..0 over valid/ready)
// Optional auto-reload mode selected by macro DCNT_RELOAD_EN.
module down_counter_seq #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [N-1:0] d,
    input  logic         ready,
    input  logic         abort,
    output logic [N-1:0] q,
    output logic         valid,
    output logic         last,
    output logic         done,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_q;
    logic         w_beat;
    logic         w_at_zero;

`ifdef DCNT_RELOAD_EN
    logic [N-1:0] r_start;
    logic         r_done;
`endif

    assign w_beat    = (r_state == S_RUN) && ready;
    assign w_at_zero = (r_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_q     <= '0;
`ifdef DCNT_RELOAD_EN
            r_start <= '0;
            r_done  <= 1'b0;
`endif
        end else begin
`ifdef DCNT_RELOAD_EN
            r_done <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (ld) begin
                        r_q     <= d;
`ifdef DCNT_RELOAD_EN
                        r_start <= d;
`endif
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // abort beats a simultaneous handshake; that beat is dropped
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (w_beat) begin
                        if (!w_at_zero) begin
                            r_q <= r_q - N'(1);
                        end else begin
`ifdef DCNT_RELOAD_EN
                            r_q    <= r_start;
                            r_done <= 1'b1;
`else
                            r_state <= S_DONE;
`endif
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign q     = r_q;
    assign valid = (r_state == S_RUN);
    assign last  = valid && w_at_zero;
    assign busy  = (r_state != S_IDLE);
`ifdef DCNT_RELOAD_EN
    assign done  = r_done;
`else
    assign done  = (r_state == S_DONE);
`endif

endmodule
